// File: rtl/axi_mgr_write_interface.sv
// ---------------------------------------------------------------------------
// axi_mgr_write_interface
//   AXI write manager. It accepts one write-burst command from the user,
//   issues a single AW transfer, streams the user's data beats onto W with
//   zero added latency, waits for the B response, then reports completion.
//
// Ports
//   m_axi_clk, m_axi_resetn     clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         user command handshake
//   cmd_addr, cmd_len           burst start address, beats minus one
//   wr_data, wr_data_valid/     user data stream, passed straight through
//   wr_data_ready               to the W channel while in the data phase
//   done, resp                  one-cycle completion pulse, last BRESP
//   m_axi_aw*                   AW channel (addr, len, valid/ready)
//   m_axi_w*                    W channel (data, valid/ready, last)
//   m_axi_b*                    B channel (resp, valid/ready)
// ---------------------------------------------------------------------------
module axi_mgr_write_interface #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  m_axi_clk,
    input  logic                  m_axi_resetn,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [3:0]            cmd_len,

    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_data_valid,
    output logic                  wr_data_ready,

    output logic                  done,
    output logic [1:0]            resp,

    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [3:0]            m_axi_awlen,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,

    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    output logic                  m_axi_wlast,

    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready
);

    localparam int unsigned LEN_W  = 4;
    localparam int unsigned RESP_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q,  addr_d;
    logic [LEN_W-1:0]        len_q,   len_d;
    logic [LEN_W-1:0]        beat_cnt_q, beat_cnt_d;
    logic                    done_q,  done_d;
    logic [RESP_W-1:0]       resp_q,  resp_d;

    // State and datapath registers
    always_ff @(posedge m_axi_clk or negedge m_axi_resetn) begin
        if (!m_axi_resetn) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            beat_cnt_q <= '0;
            done_q     <= 1'b0;
            resp_q     <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
            done_q     <= done_d;
            resp_q     <= resp_d;
        end
    end

    // Next-state and channel control
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        len_d         = len_q;
        beat_cnt_d    = beat_cnt_q;
        done_d        = 1'b0;
        resp_d        = resp_q;

        cmd_ready     = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_wdata   = '0;
        m_axi_wlast   = 1'b0;
        wr_data_ready = 1'b0;
        m_axi_bready  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    addr_d     = cmd_addr;
                    len_d      = cmd_len;
                    beat_cnt_d = '0;
                    state_d    = ST_ADDR;
                end
            end

            ST_ADDR: begin
                m_axi_awvalid = 1'b1;
                if (m_axi_awready) begin
                    state_d = ST_DATA;
                end
            end

            ST_DATA: begin
                // User stream is wired straight through; no skid buffer.
                m_axi_wvalid  = wr_data_valid;
                m_axi_wdata   = wr_data;
                wr_data_ready = m_axi_wready;
                m_axi_wlast   = (beat_cnt_q == len_q);
                if (wr_data_valid && m_axi_wready) begin
                    // Counter parks at len on the last beat so it never wraps.
                    if (beat_cnt_q == len_q) begin
                        state_d = ST_RESP;
                    end else begin
                        beat_cnt_d = beat_cnt_q + LEN_W'(1);
                    end
                end
            end

            ST_RESP: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) begin
                    resp_d  = m_axi_bresp;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign m_axi_awaddr = addr_q;
    assign m_axi_awlen  = len_q;
    assign done         = done_q;
    assign resp         = resp_q;

endmodule

// File: tb/tb_axi_mgr_write_interface.sv
// ---------------------------------------------------------------------------
// tb_axi_mgr_write_interface
//   Bench for the AXI write manager. A transaction-level model tracks which
//   phase of the burst the bus is in (accepted / address done / beats sent /
//   response taken) and predicts every output each cycle. Inputs change just
//   after the rising edge, outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_axi_mgr_write_interface;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 8;

    logic          m_axi_clk;
    logic          m_axi_resetn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [3:0]    cmd_len;
    logic [DW-1:0] wr_data;
    logic          wr_data_valid;
    logic          wr_data_ready;
    logic          done;
    logic [1:0]    resp;
    logic [AW-1:0] m_axi_awaddr;
    logic [3:0]    m_axi_awlen;
    logic          m_axi_awvalid;
    logic          m_axi_awready;
    logic [DW-1:0] m_axi_wdata;
    logic          m_axi_wvalid;
    logic          m_axi_wready;
    logic          m_axi_wlast;
    logic [1:0]    m_axi_bresp;
    logic          m_axi_bvalid;
    logic          m_axi_bready;

    axi_mgr_write_interface #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .m_axi_clk     (m_axi_clk),
        .m_axi_resetn  (m_axi_resetn),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_addr      (cmd_addr),
        .cmd_len       (cmd_len),
        .wr_data       (wr_data),
        .wr_data_valid (wr_data_valid),
        .wr_data_ready (wr_data_ready),
        .done          (done),
        .resp          (resp),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awlen   (m_axi_awlen),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_wlast   (m_axi_wlast),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready)
    );

    always #5 m_axi_clk = ~m_axi_clk;

    int         checks;
    int         failures;
    logic [1:0] last_resp;

    typedef struct {
        logic [7:0] addr;
        logic [3:0] len;
        logic [7:0] dbase;
        logic [1:0] bresp;
        int         aw_delay;
        int         wmode;      // 0 always ready, 1 wready toggles, 2 random
        int         b_delay;
        bit         early_b;
        int         exp_lat;    // accept-to-done cycles, 0 = not fixed
        logic [1:0] exp_resp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Runs one command to completion, checking every output every cycle.
    task automatic run_cmd(input logic [7:0] addr, input logic [3:0] len,
                           input logic [7:0] dbase, input logic [1:0] br,
                           input int aw_delay, input int wmode, input int b_delay,
                           input bit early_b, input bit hold_cmd, input bit pre_acc,
                           output int lat);
        logic [7:0] data [16];
        bit acc, aw_done, b_done, b_raised, fin, tog;
        bit in_addr, in_data, in_resp;
        int beat_idx, aw_wait, b_wait, acc_cyc;
        for (int i = 0; i < 16; i++) data[i] = dbase + 8'(i);
        acc = pre_acc; aw_done = 0; b_done = 0; b_raised = 0; fin = 0; tog = 0;
        beat_idx = 0; aw_wait = 0; b_wait = 0; acc_cyc = -1; lat = -1;
        for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
            @(posedge m_axi_clk); #1;
            in_addr = acc && !aw_done;
            in_data = acc && aw_done && (beat_idx <= int'(len));
            in_resp = acc && aw_done && (beat_idx > int'(len)) && !b_done;
            cmd_valid = hold_cmd ? 1'b1 : !acc;
            cmd_addr  = addr;
            cmd_len   = len;
            m_axi_awready = in_addr ? (aw_wait >= aw_delay) : 1'($urandom_range(0, 1));
            if (in_data) begin
                case (wmode)
                    0: begin m_axi_wready = 1'b1; wr_data_valid = 1'b1; end
                    1: begin m_axi_wready = tog;  wr_data_valid = 1'b1; end
                    default: begin
                        m_axi_wready  = 1'($urandom_range(0, 1));
                        wr_data_valid = 1'($urandom_range(0, 1));
                    end
                endcase
                wr_data = data[beat_idx];
            end else begin
                m_axi_wready  = 1'($urandom_range(0, 1));
                wr_data_valid = 1'($urandom_range(0, 1));
                wr_data       = 8'($urandom);
            end
            if (!b_raised && ((early_b && acc && aw_done) || (in_resp && b_wait >= b_delay)))
                b_raised = 1;
            m_axi_bvalid = b_raised && !b_done;
            m_axi_bresp  = m_axi_bvalid ? br : 2'($urandom);
            tog = !tog;

            @(negedge m_axi_clk);
            chk("cmd_ready", 32'(cmd_ready), 32'(!acc || b_done));
            chk("awvalid", 32'(m_axi_awvalid), 32'(in_addr));
            if (in_addr) begin
                chk("awaddr", 32'(m_axi_awaddr), 32'(addr));
                chk("awlen", 32'(m_axi_awlen), 32'(len));
            end
            chk("wvalid", 32'(m_axi_wvalid), 32'(in_data && wr_data_valid));
            chk("wr_data_ready", 32'(wr_data_ready), 32'(in_data && m_axi_wready));
            chk("wlast", 32'(m_axi_wlast), 32'(in_data && beat_idx == int'(len)));
            if (in_data && wr_data_valid)
                chk("wdata", 32'(m_axi_wdata), 32'(data[beat_idx]));
            chk("bready", 32'(m_axi_bready), 32'(in_resp));
            chk("done", 32'(done), 32'(b_done));
            chk("resp", 32'(resp), 32'(b_done ? br : last_resp));

            if (b_done) begin
                lat = cyc - acc_cyc;
                last_resp = br;
                chk("beat_cnt_end", 32'(dut.beat_cnt_q), 32'(len));
                fin = 1;
            end else if (!acc) begin
                acc = 1; acc_cyc = cyc;
            end else if (in_addr) begin
                if (m_axi_awready) aw_done = 1; else aw_wait++;
            end else if (in_data) begin
                if (wr_data_valid && m_axi_wready) beat_idx++;
            end else if (in_resp) begin
                if (m_axi_bvalid) b_done = 1; else b_wait++;
            end
        end
        if (!fin) chk("burst_timeout", 32'(0), 32'(1));
    endtask

    initial begin
        vec_t vecs [6];
        int   lat;
        logic [3:0] rlen;

        checks = 0; failures = 0; last_resp = 2'b00;
        m_axi_clk = 1'b0; m_axi_resetn = 1'b0;
        cmd_valid = 0; cmd_addr = '0; cmd_len = '0; wr_data = '0; wr_data_valid = 0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bresp = '0; m_axi_bvalid = 0;

        vecs[0] = '{8'h10, 4'd0,  8'hA5, 2'b00, 0, 0, 0, 1'b0, 4,  2'b00};
        vecs[1] = '{8'h20, 4'd3,  8'h01, 2'b00, 0, 0, 0, 1'b0, 7,  2'b00};
        vecs[2] = '{8'h30, 4'd5,  8'h50, 2'b00, 3, 1, 0, 1'b0, 0,  2'b00};
        vecs[3] = '{8'h44, 4'd1,  8'hC0, 2'b10, 0, 0, 2, 1'b0, 7,  2'b10};
        vecs[4] = '{8'h55, 4'd15, 8'h00, 2'b11, 0, 0, 0, 1'b1, 19, 2'b11};
        vecs[5] = '{8'h66, 4'd2,  8'hF0, 2'b01, 1, 0, 0, 1'b0, 7,  2'b01};

        #3;
        chk("rst_awvalid", 32'(m_axi_awvalid), 32'(0));
        chk("rst_wvalid", 32'(m_axi_wvalid), 32'(0));
        chk("rst_bready", 32'(m_axi_bready), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_resp", 32'(resp), 32'(0));
        chk("rst_cmd_ready", 32'(cmd_ready), 32'(1));
        #9 m_axi_resetn = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_cmd(vecs[i].addr, vecs[i].len, vecs[i].dbase, vecs[i].bresp,
                    vecs[i].aw_delay, vecs[i].wmode, vecs[i].b_delay,
                    vecs[i].early_b, 1'b0, 1'b0, lat);
            if (vecs[i].exp_lat != 0) chk("latency", 32'(lat), 32'(vecs[i].exp_lat));
            chk("resp_after", 32'(resp), 32'(vecs[i].exp_resp));
        end

        // Reset during beat 2 of a len=3 burst.
        @(posedge m_axi_clk); #1;
        cmd_valid = 1; cmd_addr = 8'h77; cmd_len = 4'd3; m_axi_awready = 1;
        m_axi_wready = 1; wr_data_valid = 1; wr_data = 8'h11; m_axi_bvalid = 0;
        @(posedge m_axi_clk); #1; cmd_valid = 0;
        @(posedge m_axi_clk); #1; wr_data = 8'h11;
        @(posedge m_axi_clk); #1; wr_data = 8'h22;
        @(negedge m_axi_clk);
        chk("beat2_wvalid", 32'(m_axi_wvalid), 32'(1));
        chk("beat2_wdata", 32'(m_axi_wdata), 32'(8'h22));
        chk("beat2_wlast", 32'(m_axi_wlast), 32'(0));
        #1 m_axi_resetn = 1'b0;
        #1;
        chk("mid_rst_awvalid", 32'(m_axi_awvalid), 32'(0));
        chk("mid_rst_wvalid", 32'(m_axi_wvalid), 32'(0));
        chk("mid_rst_wlast", 32'(m_axi_wlast), 32'(0));
        chk("mid_rst_wrdy", 32'(wr_data_ready), 32'(0));
        chk("mid_rst_bready", 32'(m_axi_bready), 32'(0));
        chk("mid_rst_done", 32'(done), 32'(0));
        chk("mid_rst_resp", 32'(resp), 32'(0));
        chk("mid_rst_awaddr", 32'(m_axi_awaddr), 32'(0));
        chk("mid_rst_awlen", 32'(m_axi_awlen), 32'(0));
        chk("mid_rst_cnt", 32'(dut.beat_cnt_q), 32'(0));
        wr_data_valid = 0; m_axi_wready = 0; m_axi_awready = 0;
        repeat (2) begin
            @(negedge m_axi_clk);
            chk("rst_hold_done", 32'(done), 32'(0));
        end
        m_axi_resetn = 1'b1;
        last_resp = 2'b00;
        repeat (3) begin
            @(negedge m_axi_clk);
            chk("post_rst_done", 32'(done), 32'(0));
            chk("post_rst_cmd_ready", 32'(cmd_ready), 32'(1));
        end
        run_cmd(8'h12, 4'd0, 8'h3C, 2'b00, 0, 0, 0, 1'b0, 1'b0, 1'b0, lat);
        chk("post_rst_latency", 32'(lat), 32'(4));

        // Back-to-back with cmd_valid held: second accepted on the done cycle.
        run_cmd(8'h88, 4'd2, 8'h30, 2'b00, 0, 0, 0, 1'b0, 1'b1, 1'b0, lat);
        chk("b2b_first_latency", 32'(lat), 32'(6));
        run_cmd(8'h88, 4'd2, 8'h30, 2'b01, 1, 0, 1, 1'b0, 1'b0, 1'b1, lat);
        chk("b2b_second_latency", 32'(lat), 32'(8));

        // Randomized commands and bus behaviour.
        for (int n = 0; n < 30; n++) begin
            rlen = 4'($urandom_range(0, 15));
            run_cmd(8'($urandom), rlen, 8'($urandom), 2'($urandom),
                    int'($urandom_range(0, 3)), 2, int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'b0, 1'b0, lat);
            chk("rand_lat_min", 32'(lat >= int'(rlen) + 4), 32'(1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
